// File: rtl/i_type_dispatch.sv
// i_type_dispatch: RV32I OP-IMM operand supply and writeback, owning the integer register file.
//   clk, rst            clock; asynchronous active-high reset
//   instr_valid/ready   fetch handshake (ready only in IDLE with flush low)
//   instr, flush        instruction word; abort of the in-flight instruction
//   idata, rv1, imm     held word, rs1 value, sign-extended I-immediate to the execution unit
//   regdata_I           combinational execution unit result
//   retire_*, illegal   completion pulse with rd/data; rejection pulse
//   dbg_addr/dbg_data   combinational register file read port
module i_type_dispatch #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            instr_valid,
   output logic            instr_ready,
   input  logic [31:0]     instr,
   input  logic            flush,
   output logic [31:0]     idata,
   output logic [XLEN-1:0] rv1,
   output logic [XLEN-1:0] imm,
   input  logic [XLEN-1:0] regdata_I,
   output logic            retire_valid,
   output logic [4:0]      retire_rd,
   output logic [XLEN-1:0] retire_data,
   output logic            illegal,
   input  logic [4:0]      dbg_addr,
   output logic [XLEN-1:0] dbg_data
);
   typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;
   state_t state, state_n;
   logic [XLEN-1:0] rf [NREGS];
   logic accept, legal;
   logic [6:0] f7;
   logic [2:0] f3;
   assign f7 = instr[31:25];
   assign f3 = instr[14:12];
   // shifts carry their funct7 in the immediate field, so only those encodings are checked
   assign legal = (instr[6:0] == 7'b0010011) &&
                  (f3 == 3'b001 ? f7 == 7'h00 :
                   f3 == 3'b101 ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1);
   assign instr_ready = (state == IDLE) && !flush && !rst;
   assign accept = instr_valid && instr_ready;
   assign dbg_data = (dbg_addr == 5'd0) ? '0 : rf[dbg_addr];
   always_comb begin
      state_n = IDLE;
      retire_valid = 1'b0;
      retire_rd = 5'd0;
      if (state == IDLE)
         state_n = (accept && legal) ? EXEC : IDLE;
      else if (state == EXEC)
         state_n = flush ? IDLE : WB;
      else begin
         retire_valid = !flush;
         retire_rd = retire_valid ? idata[11:7] : 5'd0;
      end
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         idata <= '0;
         rv1 <= '0;
         imm <= '0;
         retire_data <= '0;
         illegal <= 1'b0;
         for (int i = 0; i < NREGS; i++) rf[i] <= '0;
      end else begin
         state <= state_n;
         illegal <= accept && !legal;
         if (accept) idata <= instr;
         if (accept && legal) begin
            rv1 <= (instr[19:15] == 5'd0) ? '0 : rf[instr[19:15]];
            imm <= {{(XLEN-12){instr[31]}}, instr[31:20]};
         end
         if (state == EXEC) retire_data <= regdata_I;
         if (retire_valid && idata[11:7] != 5'd0) rf[idata[11:7]] <= retire_data;
      end
   end
endmodule

// File: tb/tb_i_type_dispatch.sv
// tb_i_type_dispatch: directed and randomized checks of i_type_dispatch against a register-file model.
module tb_i_type_dispatch;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic instr_valid = 1'b0;
   logic instr_ready;
   logic [31:0] instr = 32'h0;
   logic flush = 1'b0;
   logic [31:0] idata, rv1, imm, regdata_I, retire_data, dbg_data;
   logic retire_valid, illegal;
   logic [4:0] retire_rd;
   logic [4:0] dbg_addr = 5'd0;
   int checks = 0;
   int failures = 0;
   logic [31:0] model [32];

   i_type_dispatch dut (
      .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instr(instr), .flush(flush), .idata(idata), .rv1(rv1), .imm(imm),
      .regdata_I(regdata_I), .retire_valid(retire_valid), .retire_rd(retire_rd),
      .retire_data(retire_data), .illegal(illegal), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] alu(input logic [2:0] f3, input logic alt, input logic [31:0] a, input logic [31:0] b);
      case (f3)
         3'd0: return a + b;
         3'd1: return a << b[4:0];
         3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         3'd3: return (a < b) ? 32'd1 : 32'd0;
         3'd4: return a ^ b;
         3'd5: return alt ? $unsigned($signed(a) >>> b[4:0]) : a >> b[4:0];
         3'd6: return a | b;
         default: return a & b;
      endcase
   endfunction

   function automatic logic [31:0] sext(input logic [31:0] w);
      return {{20{w[31]}}, w[31:20]};
   endfunction

   function automatic logic is_legal(input logic [31:0] w);
      if (w[6:0] != 7'h13) return 1'b0;
      if (w[14:12] == 3'd1) return w[31:25] == 7'h00;
      if (w[14:12] == 3'd5) return w[31:25] == 7'h00 || w[31:25] == 7'h20;
      return 1'b1;
   endfunction

   // execution unit the dispatch block drives
   always_comb regdata_I = alu(idata[14:12], idata[30], rv1, imm);

   task automatic send(input logic [31:0] w, output logic rdy, output logic ill, output logic nrdy,
                       output logic [31:0] erv, output logic [31:0] eimm, output logic rv,
                       output logic [4:0] rd, output logic [31:0] data);
      @(negedge clk);
      instr = w;
      instr_valid = 1'b1;
      #1 rdy = instr_ready;
      @(negedge clk);
      instr_valid = 1'b0;
      ill = illegal;
      nrdy = instr_ready;
      erv = rv1;
      eimm = imm;
      rv = retire_valid;
      rd = 5'd0;
      data = 32'd0;
      if (!ill) begin
         @(negedge clk);
         rv = retire_valid;
         rd = retire_rd;
         data = retire_data;
         @(negedge clk);
      end
   endtask

   task automatic peek(input logic [4:0] a, output logic [31:0] d);
      dbg_addr = a;
      #1 d = dbg_data;
   endtask

   task automatic test_reset;
      instr_valid = 1'b1;
      instr = 32'h00500093;
      repeat (2) @(negedge clk);
      checks++;
      if (instr_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", instr_ready); end
      checks++;
      if ({retire_valid, illegal} !== 2'b00) begin failures++; $display("FAIL reset_pulses got=%b exp=00", {retire_valid, illegal}); end
      checks++;
      if ({idata, rv1, imm, retire_data} !== 128'd0) begin failures++; $display("FAIL reset_regs idata=%h rv1=%h imm=%h rdata=%h exp=0", idata, rv1, imm, retire_data); end
      rst = 1'b0;
      instr_valid = 1'b0;
      #1;
      checks++;
      if (instr_ready !== 1'b1) begin failures++; $display("FAIL reset_release_ready got=%b exp=1", instr_ready); end
   endtask

   task automatic test_addi;
      logic rdy, ill, nrdy, rv;
      logic [31:0] erv, eimm, data, d;
      logic [4:0] rd;
      send(32'h00500093, rdy, ill, nrdy, erv, eimm, rv, rd, data);
      checks++;
      if ({rdy, ill, rv} !== 3'b101) begin failures++; $display("FAIL addi_flags rdy/ill/rv got=%b exp=101", {rdy, ill, rv}); end
      checks++;
      if (rd !== 5'd1 || data !== 32'd5) begin failures++; $display("FAIL addi_retire rd=%0d data=%h exp rd=1 data=5", rd, data); end
      peek(5'd1, d);
      checks++;
      if (d !== 32'd5) begin failures++; $display("FAIL addi_dbg got=%h exp=00000005", d); end
   endtask

   task automatic test_srai;
      logic rdy, ill, nrdy, rv;
      logic [31:0] erv, eimm, data, d;
      logic [4:0] rd;
      send(32'hFF800113, rdy, ill, nrdy, erv, eimm, rv, rd, data);
      checks++;
      if (rv !== 1'b1 || rd !== 5'd2 || data !== 32'hFFFFFFF8) begin failures++; $display("FAIL neg_addi rv=%b rd=%0d data=%h exp 1/2/fffffff8", rv, rd, data); end
      send(32'h40115193, rdy, ill, nrdy, erv, eimm, rv, rd, data);
      checks++;
      if (eimm !== 32'h00000401 || erv !== 32'hFFFFFFF8) begin failures++; $display("FAIL srai_operands imm=%h rv1=%h exp 00000401/fffffff8", eimm, erv); end
      checks++;
      if (rv !== 1'b1 || rd !== 5'd3 || data !== 32'hFFFFFFFC) begin failures++; $display("FAIL srai_retire rv=%b rd=%0d data=%h exp 1/3/fffffffc", rv, rd, data); end
      peek(5'd3, d);
      checks++;
      if (d !== 32'hFFFFFFFC) begin failures++; $display("FAIL srai_dbg got=%h exp=fffffffc", d); end
   endtask

   task automatic test_x0;
      logic rdy, ill, nrdy, rv;
      logic [31:0] erv, eimm, data, d;
      logic [4:0] rd;
      send(32'h00700013, rdy, ill, nrdy, erv, eimm, rv, rd, data);
      checks++;
      if (rv !== 1'b1 || rd !== 5'd0 || data !== 32'd7) begin failures++; $display("FAIL x0_retire rv=%b rd=%0d data=%h exp 1/0/7", rv, rd, data); end
      peek(5'd0, d);
      checks++;
      if (d !== 32'd0) begin failures++; $display("FAIL x0_dbg got=%h exp=0", d); end
   endtask

   task automatic test_illegal;
      logic [31:0] words [2] = '{32'h002081B3, 32'h40111193};
      logic rdy, ill, nrdy, rv;
      logic [31:0] erv, eimm, data, d;
      logic [4:0] rd;
      for (int i = 0; i < 2; i++) begin
         send(words[i], rdy, ill, nrdy, erv, eimm, rv, rd, data);
         checks++;
         if ({ill, nrdy, rv} !== 3'b110) begin failures++; $display("FAIL illegal_pulse w=%h ill/ready/rv got=%b exp=110", words[i], {ill, nrdy, rv}); end
         @(negedge clk);
         checks++;
         if ({retire_valid, illegal} !== 2'b00) begin failures++; $display("FAIL illegal_after w=%h rv/ill got=%b exp=00", words[i], {retire_valid, illegal}); end
      end
      peek(5'd3, d);
      checks++;
      if (d !== 32'hFFFFFFFC) begin failures++; $display("FAIL illegal_x3 got=%h exp=fffffffc", d); end
   endtask

   task automatic test_flush;
      logic [31:0] d;
      @(negedge clk);
      instr = 32'h00900213;
      instr_valid = 1'b1;
      @(negedge clk);
      instr_valid = 1'b0;
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      #1;
      checks++;
      if (retire_valid !== 1'b0 || instr_ready !== 1'b1) begin failures++; $display("FAIL flush_exec rv=%b ready=%b exp 0/1", retire_valid, instr_ready); end
      @(negedge clk);
      peek(5'd4, d);
      checks++;
      if (retire_valid !== 1'b0 || d !== 32'd0) begin failures++; $display("FAIL flush_exec_x4 rv=%b x4=%h exp 0/0", retire_valid, d); end
      instr = 32'h00300313;
      instr_valid = 1'b1;
      @(negedge clk);
      instr_valid = 1'b0;
      @(negedge clk);
      flush = 1'b1;
      #1;
      checks++;
      if (retire_valid !== 1'b0) begin failures++; $display("FAIL flush_wb_retire got=%b exp=0", retire_valid); end
      @(negedge clk);
      flush = 1'b0;
      peek(5'd6, d);
      checks++;
      if (d !== 32'd0) begin failures++; $display("FAIL flush_wb_x6 got=%h exp=0", d); end
      @(negedge clk);
      instr = 32'h00A00393;
      instr_valid = 1'b1;
      flush = 1'b1;
      #1;
      checks++;
      if (instr_ready !== 1'b0) begin failures++; $display("FAIL flush_idle_ready got=%b exp=0", instr_ready); end
      @(negedge clk);
      instr_valid = 1'b0;
      flush = 1'b0;
      checks++;
      if (idata !== 32'h00300313) begin failures++; $display("FAIL flush_idle_idata got=%h exp=00300313", idata); end
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         checks++;
         if (retire_valid !== 1'b0) begin failures++; $display("FAIL flush_idle_retire cyc=%0d got=%b exp=0", i, retire_valid); end
      end
      peek(5'd7, d);
      checks++;
      if (d !== 32'd0) begin failures++; $display("FAIL flush_idle_x7 got=%h exp=0", d); end
   endtask

   task automatic test_reset_mid;
      logic [31:0] d;
      int bad = 0;
      @(negedge clk);
      instr = 32'h00100293;
      instr_valid = 1'b1;
      @(negedge clk);
      instr_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #1;
      checks++;
      if ({retire_valid, illegal, instr_ready} !== 3'b000) begin failures++; $display("FAIL rst_mid_outputs rv/ill/ready got=%b exp=000", {retire_valid, illegal, instr_ready}); end
      @(negedge clk);
      checks++;
      if ({retire_valid, instr_ready} !== 2'b00) begin failures++; $display("FAIL rst_mid_hold rv/ready got=%b exp=00", {retire_valid, instr_ready}); end
      for (int i = 0; i < 32; i++) begin
         peek(5'(i), d);
         if (d !== 32'd0) bad++;
      end
      checks++;
      if (bad != 0) begin failures++; $display("FAIL rst_mid_rf nonzero_regs=%0d exp=0", bad); end
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++;
      if (instr_ready !== 1'b1 || retire_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_release ready=%b rv=%b exp 1/0", instr_ready, retire_valid); end
      for (int i = 0; i < 32; i++) model[i] = 32'd0;
   endtask

   task automatic test_random;
      logic rdy, ill, nrdy, rv, lg;
      logic [31:0] erv, eimm, data, d, w, exp_v;
      logic [4:0] rd, rs1, rdw;
      logic [2:0] f3;
      logic [11:0] i12;
      for (int n = 0; n < 60; n++) begin
         f3 = 3'($urandom_range(0, 7));
         rs1 = 5'($urandom);
         rdw = 5'($urandom);
         i12 = 12'($urandom);
         if (f3 == 3'd1) i12[11:5] = 7'h00;
         if (f3 == 3'd5) i12[11:5] = $urandom_range(0, 1) ? 7'h20 : 7'h00;
         w = {i12, rs1, f3, rdw, 7'h13};
         case ($urandom_range(0, 7))
            0: w[6:0] = 7'h33;
            1: if (f3 == 3'd1 || f3 == 3'd5) w[31:25] = 7'h01;
            default: ;
         endcase
         lg = is_legal(w);
         exp_v = alu(f3, w[30], model[rs1], sext(w));
         send(w, rdy, ill, nrdy, erv, eimm, rv, rd, data);
         checks++;
         if (rdy !== 1'b1 || ill !== !lg) begin failures++; $display("FAIL rand_accept n=%0d w=%h rdy=%b ill=%b exp rdy=1 ill=%b", n, w, rdy, ill, !lg); end
         if (lg) begin
            checks++;
            if (erv !== model[rs1] || eimm !== sext(w)) begin failures++; $display("FAIL rand_operands n=%0d w=%h rv1=%h imm=%h exp %h/%h", n, w, erv, eimm, model[rs1], sext(w)); end
            checks++;
            if (rv !== 1'b1 || rd !== rdw || data !== exp_v) begin failures++; $display("FAIL rand_retire n=%0d w=%h rv=%b rd=%0d data=%h exp 1/%0d/%h", n, w, rv, rd, data, rdw, exp_v); end
            if (rdw != 5'd0) model[rdw] = exp_v;
            peek(rdw, d);
            checks++;
            if (d !== model[rdw]) begin failures++; $display("FAIL rand_dbg n=%0d x%0d got=%h exp=%h", n, rdw, d, model[rdw]); end
         end
      end
   endtask

   initial begin
      test_reset;
      test_addi;
      test_srai;
      test_x0;
      test_illegal;
      test_flush;
      test_reset_mid;
      test_random;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
      $fatal(1);
   end
endmodule
